// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch unit: jump-type codes, FSM state
// encoding and the default reset vector.
package fetch_pkg;

  localparam logic [1:0] JT_REG   = 2'b00;
  localparam logic [1:0] JT_IMM16 = 2'b01;
  localparam logic [1:0] JT_IMM26 = 2'b10;
  localparam logic [1:0] JT_IAR   = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_target.sv
// Resolves whether a control transfer is taken and computes its word-aligned target.
// Purely combinational; no state and no flow control.
module fetch_target
  import fetch_pkg::*;
(
  input  logic [1:0]  i_jump_type,
  input  logic        i_is_branch,
  input  logic        i_cond_src,
  input  logic        i_branch_cond,
  input  logic [31:0] i_alu_out,
  input  logic        i_fpsr,
  input  logic [31:0] i_reg_a,
  input  logic [31:0] i_iar,
  input  logic [31:0] i_redirect_pc4,
  input  logic [25:0] i_redirect_imm,
  output logic        o_taken,
  output logic [31:0] o_target
);

  logic        w_cond;
  logic [31:0] w_raw;

  assign w_cond  = i_cond_src ? (i_alu_out == 32'd0) : i_fpsr;
  assign o_taken = !i_is_branch || (w_cond == i_branch_cond);

  // The 16-bit offset is the low half of the 26-bit immediate field.
  always_comb begin
    w_raw = i_reg_a;
    case (i_jump_type)
      JT_REG:   w_raw = i_reg_a;
      JT_IMM16: w_raw = i_redirect_pc4 + {{16{i_redirect_imm[15]}}, i_redirect_imm[15:0]};
      JT_IMM26: w_raw = i_redirect_pc4 + {{6{i_redirect_imm[25]}}, i_redirect_imm};
      JT_IAR:   w_raw = i_iar;
      default:  w_raw = i_reg_a;
    endcase
  end

  assign o_target = {w_raw[31:2], 2'b00};

endmodule

// File: rtl/fetch_unit.sv
// Single-entry instruction fetch buffer with redirect handling; one instruction per
// two cycles peak. Holds the buffered instruction while decode is not ready.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] inst_pc4,
  input  logic        redirect_valid,
  input  logic [1:0]  jump_type,
  input  logic        is_branch,
  input  logic        cond_src,
  input  logic        branch_cond,
  input  logic [31:0] alu_out,
  input  logic        fpsr,
  input  logic [31:0] reg_a,
  input  logic [31:0] iar,
  input  logic [31:0] redirect_pc4,
  input  logic [25:0] redirect_imm
);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_drop_addr;
  logic        r_inst_valid;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc4;

  logic        w_taken;
  logic [31:0] w_target;
  logic        w_redirect;
  logic [31:0] w_pc_inc;

  fetch_target u_target (
    .i_jump_type    (jump_type),
    .i_is_branch    (is_branch),
    .i_cond_src     (cond_src),
    .i_branch_cond  (branch_cond),
    .i_alu_out      (alu_out),
    .i_fpsr         (fpsr),
    .i_reg_a        (reg_a),
    .i_iar          (iar),
    .i_redirect_pc4 (redirect_pc4),
    .i_redirect_imm (redirect_imm),
    .o_taken        (w_taken),
    .o_target       (w_target)
  );

  assign w_redirect = redirect_valid && w_taken;
  assign w_pc_inc   = r_pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_drop_addr  <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_inst       <= 32'd0;
      r_inst_pc4   <= 32'd0;
    end else begin
      if (w_redirect) begin
        r_pc         <= w_target;
        r_inst_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (w_redirect) begin
            // The outstanding read must finish at its original address before refetching.
            if (!imem_ack) begin
              r_drop_addr <= r_pc;
              r_state     <= S_DROP;
            end
          end else if (imem_ack) begin
            r_inst       <= imem_rdata;
            r_inst_pc4   <= w_pc_inc;
            r_pc         <= w_pc_inc;
            r_inst_valid <= 1'b1;
            r_state      <= S_FULL;
          end
        end
        S_FULL: begin
          if (w_redirect) begin
            r_state <= S_FETCH;
          end else if (inst_ready) begin
            r_inst_valid <= 1'b0;
            r_state      <= S_FETCH;
          end
        end
        // Any ack here completes the abandoned read, so the newest pc is fetched next.
        S_DROP: if (imem_ack) r_state <= S_FETCH;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req   = (r_state == S_FETCH) || (r_state == S_DROP);
  assign imem_addr  = (r_state == S_DROP) ? r_drop_addr : r_pc;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc4   = r_inst_pc4;
  assign opcode     = r_inst[31:26];
  assign funct      = r_inst[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch sequencing, stall, branch/jump redirects,
// drop handling, reset mid-request and pc wrap.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] inst_pc4;
  logic        redirect_valid;
  logic [1:0]  jump_type;
  logic        is_branch;
  logic        cond_src;
  logic        branch_cond;
  logic [31:0] alu_out;
  logic        fpsr;
  logic [31:0] reg_a;
  logic [31:0] iar;
  logic [31:0] redirect_pc4;
  logic [25:0] redirect_imm;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .opcode         (opcode),
    .funct          (funct),
    .inst_pc4       (inst_pc4),
    .redirect_valid (redirect_valid),
    .jump_type      (jump_type),
    .is_branch      (is_branch),
    .cond_src       (cond_src),
    .branch_cond    (branch_cond),
    .alu_out        (alu_out),
    .fpsr           (fpsr),
    .reg_a          (reg_a),
    .iar            (iar),
    .redirect_pc4   (redirect_pc4),
    .redirect_imm   (redirect_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic no_redirect();
    redirect_valid = 1'b0;
    jump_type      = 2'b00;
    is_branch      = 1'b0;
    cond_src       = 1'b0;
    branch_cond    = 1'b0;
    alu_out        = 32'd0;
    fpsr           = 1'b0;
    reg_a          = 32'd0;
    iar            = 32'd0;
    redirect_pc4   = 32'd0;
    redirect_imm   = 26'd0;
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    inst_ready = 1'b0;
    no_redirect();

    // Reset state
    tick();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc4", inst_pc4, 0);
    chk("rst_addr", imem_addr, 32'h0);
    #2 rst_n = 1'b1;

    // Sequential fetch 0,4,8
    tick();
    chk("f0_req", imem_req, 1);
    chk("f0_addr", imem_addr, 32'h0);
    imem_rdata = 32'h2001_0005;
    imem_ack   = 1'b1;
    tick();
    chk("f0_valid", inst_valid, 1);
    chk("f0_req_off", imem_req, 0);
    chk("f0_inst", inst, 32'h2001_0005);
    chk("f0_opcode", opcode, 32'h08);
    chk("f0_funct", funct, 32'h05);
    chk("f0_pc4", inst_pc4, 32'h4);
    imem_ack   = 1'b0;
    inst_ready = 1'b1;
    tick();
    chk("f1_addr", imem_addr, 32'h4);
    chk("f1_valid", inst_valid, 0);
    imem_ack = 1'b1;
    tick();
    chk("f1_pc4", inst_pc4, 32'h8);
    imem_ack = 1'b0;
    tick();
    chk("f2_addr", imem_addr, 32'h8);
    chk("f2_req", imem_req, 1);
    imem_ack   = 1'b1;
    inst_ready = 1'b0;
    tick();
    chk("f2_pc4", inst_pc4, 32'hC);

    // Stall in FULL for 5 cycles
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", inst_valid, 1);
      chk("stall_req", imem_req, 0);
      chk("stall_inst", inst, 32'h2001_0005);
    end
    inst_ready = 1'b1;
    tick();
    chk("stall_next_addr", imem_addr, 32'hC);
    inst_ready = 1'b0;
    imem_ack   = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("f3_valid", inst_valid, 1);

    // Taken BEQZ from FULL: 0x100 + (-16) = 0xF0
    redirect_valid = 1'b1;
    jump_type      = 2'b01;
    is_branch      = 1'b1;
    cond_src       = 1'b1;
    branch_cond    = 1'b1;
    alu_out        = 32'd0;
    redirect_pc4   = 32'h100;
    redirect_imm   = 26'h000_FFF0;
    tick();
    no_redirect();
    chk("beqz_addr", imem_addr, 32'hF0);
    chk("beqz_valid", inst_valid, 0);
    chk("beqz_req", imem_req, 1);
    imem_rdata = 32'h1111_2222;
    imem_ack   = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("beqz_pc4", inst_pc4, 32'hF4);

    // Not-taken BEQZ (alu_out != 0) has no effect
    redirect_valid = 1'b1;
    jump_type      = 2'b01;
    is_branch      = 1'b1;
    cond_src       = 1'b1;
    branch_cond    = 1'b1;
    alu_out        = 32'd1;
    redirect_pc4   = 32'h100;
    redirect_imm   = 26'h000_FFF0;
    tick();
    no_redirect();
    chk("nt_valid", inst_valid, 1);
    chk("nt_req", imem_req, 0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("nt_addr", imem_addr, 32'hF4);

    // IAR jump in FETCH without ack -> DROP
    redirect_valid = 1'b1;
    jump_type      = 2'b11;
    iar            = 32'h2000;
    tick();
    no_redirect();
    chk("drop_req", imem_req, 1);
    chk("drop_addr0", imem_addr, 32'hF4);
    chk("drop_valid", inst_valid, 0);
    tick();
    chk("drop_addr1", imem_addr, 32'hF4);
    imem_rdata = 32'hBAD0_BAD0;
    imem_ack   = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("drop_new_addr", imem_addr, 32'h2000);
    chk("drop_discard_valid", inst_valid, 0);
    chk("drop_discard_inst", inst, 32'h1111_2222);
    chk("drop_discard_pc4", inst_pc4, 32'hF4);

    // Redirects while in DROP: newest target wins
    redirect_valid = 1'b1;
    jump_type      = 2'b11;
    iar            = 32'h3000;
    tick();
    chk("drop2_addr", imem_addr, 32'h2000);
    jump_type = 2'b00;
    reg_a     = 32'h5000;
    tick();
    no_redirect();
    chk("drop3_addr", imem_addr, 32'h2000);
    chk("drop3_req", imem_req, 1);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("drop3_new_addr", imem_addr, 32'h5000);

    // JumpReg in FULL with inst_ready=1
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("jr_full_pc4", inst_pc4, 32'h5004);
    redirect_valid = 1'b1;
    jump_type      = 2'b00;
    reg_a          = 32'h403;
    inst_ready     = 1'b1;
    tick();
    no_redirect();
    inst_ready = 1'b0;
    chk("jr_valid", inst_valid, 0);
    chk("jr_addr", imem_addr, 32'h400);

    // Reset while request outstanding
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_req", imem_req, 0);
    chk("mrst_valid", inst_valid, 0);
    chk("mrst_inst", inst, 0);
    chk("mrst_pc4", inst_pc4, 0);
    chk("mrst_addr", imem_addr, 32'h0);
    imem_ack = 1'b1;
    tick();
    chk("mrst_hold_req", imem_req, 0);
    #2 rst_n = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("mrst_stray_valid", inst_valid, 0);
    chk("mrst_restart_req", imem_req, 1);
    chk("mrst_restart_addr", imem_addr, 32'h0);
    imem_rdata = 32'h2001_0005;
    imem_ack   = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("mrst_fetch_pc4", inst_pc4, 32'h4);

    // Imm26 jump with negative offset: 0x1000 - 16 = 0xFF0
    redirect_valid = 1'b1;
    jump_type      = 2'b10;
    redirect_pc4   = 32'h1000;
    redirect_imm   = 26'h3FF_FFF0;
    tick();
    no_redirect();
    chk("imm26_addr", imem_addr, 32'hFF0);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;

    // Unaligned IAR target is word-aligned, then pc wraps to 0
    redirect_valid = 1'b1;
    jump_type      = 2'b11;
    iar            = 32'hFFFF_FFFF;
    tick();
    no_redirect();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("wrap_pc4", inst_pc4, 32'h0);
    inst_ready = 1'b1;
    tick();
    chk("wrap_next_addr", imem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first instruction address after reset.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 imem_req  out  1  instruction-memory read request.
REQ-005 imem_addr  out  32  word address of request.
REQ-006 imem_ack  in  1  read complete; imem_rdata valid this cycle.
REQ-007 imem_rdata  in  32  fetched instruction.
REQ-008 inst_valid  out  1  instruction buffer holds an instruction for decode.
REQ-009 inst_ready  in  1  decode accepts buffered instruction.
REQ-010 inst  out  32  buffered instruction; opcode out 6 = inst[0:5]; funct out 6 = inst[26:31] (combinational slices).
REQ-011 inst_pc4  out  32  address of buffered instruction + 4 (link value).
REQ-012 redirect_valid  in  1  a control-transfer instruction is resolved this cycle.
REQ-013 jump_type  in  2  00 JumpReg, 01 Imm16, 10 Imm26, 11 IAR.
REQ-014 is_branch  in  1  transfer is conditional; cond_src in 1 (0 FPSR, 1 ALUOut); branch_cond in 1 (1 taken-on-true, 0 taken-on-false).
REQ-015 alu_out in 32, fpsr in 1, reg_a in 32, iar in 32, redirect_pc4 in 32, redirect_imm in 26: condition and target operands.

Function
REQ-016 States SHALL be IDLE, FETCH, FULL, DROP.
REQ-017 imem_req SHALL be 1 exactly in FETCH and DROP; imem_addr SHALL equal pc and SHALL not change while imem_req=1 until imem_ack.
REQ-018 IDLE SHALL go to FETCH on the first clock after reset release.
REQ-019 FETCH with imem_ack, no redirect: inst<=imem_rdata, inst_pc4<=pc+4, pc<=pc+4, inst_valid<=1, go FULL.
REQ-020 FULL with inst_ready, no redirect: inst_valid<=0, go FETCH; without inst_ready hold all state.
REQ-021 Peak throughput SHALL be one instruction per two cycles with single-cycle ack.
REQ-022 cond = cond_src ? (alu_out==0) : fpsr; taken = !is_branch | (cond==branch_cond).
REQ-023 Target: 00 reg_a; 01 redirect_pc4 + sext(redirect_imm[10:25]); 10 redirect_pc4 + sext(redirect_imm); 11 iar; addition modulo 2^32; two LSBs forced to 0.
REQ-024 Effective redirect = redirect_valid & taken; not-taken branch SHALL have no effect.
REQ-025 Effective redirect SHALL set pc<=target and inst_valid<=0 in every state, overriding inst_ready and imem_ack handling that cycle.
REQ-026 Redirect in IDLE, FULL, or FETCH with same-cycle imem_ack: discard rdata, go FETCH.
REQ-027 Redirect in FETCH without imem_ack: go DROP; DROP keeps old imem_addr until imem_ack, discards rdata, then FETCH at new pc.
REQ-028 Redirect in DROP: pc<=newest target, remain DROP.
REQ-029 pc increment SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000.

Reset
REQ-030 While rst_n=0: state IDLE, pc=RESET_PC, imem_req=0, inst_valid=0, inst=0, inst_pc4=0, immediately on assertion.
REQ-031 Reset mid-request SHALL abandon the request; a later imem_ack SHALL be ignored until FETCH is re-entered.

Structure
REQ-032 Package fetch_pkg SHALL hold jump-type constants (JT_REG, JT_IMM16, JT_IMM26, JT_IAR), state encoding, and default RESET_PC.
REQ-033 Sub-module fetch_target (combinational taken/target, REQ-022..023) SHALL be instantiated once.

Verification
REQ-034 Reset release, imem_ack each request, inst_ready=1, rdata=0x20010005 -> addresses 0,4,8; opcode=0x08; inst_pc4=4 first.
REQ-035 FULL, inst_ready=0 for 5 cycles -> inst_valid=1, imem_req=0, inst stable.
REQ-036 BEQZ: jump_type=01, cond_src=1, branch_cond=1, alu_out=0, redirect_pc4=0x100, imm low16=0xFFF0 -> next imem_addr 0xF0; alu_out=1 -> no redirect.
REQ-037 Redirect (jump_type=11, iar=0x2000) in FETCH without ack -> DROP, addr held until ack, rdata discarded, then imem_addr=0x2000.
REQ-038 Redirect jump_type=00 reg_a=0x403 in FULL with inst_ready=1 -> inst_valid=0, next addr 0x400.
REQ-039 rst_n low during outstanding request -> outputs reset immediately; stray imem_ack ignored; fetch restarts at RESET_PC.
